// File: rtl/nco_ctrl_pkg.sv
// Shared types for the NCO sweep controller: FSM states, default widths and
// the latched sweep descriptor.
package nco_ctrl_pkg;

    localparam int unsigned DEF_PHASE_WIDTH = 64;
    localparam int unsigned DEF_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic signed [DEF_PHASE_WIDTH-1:0] start;
        logic signed [DEF_PHASE_WIDTH-1:0] stop;
        logic        [DEF_PHASE_WIDTH-1:0] step;
        logic        [DEF_DWELL_WIDTH-1:0] dwell;
        logic                              continuous;
    } sweep_desc_t;

endpackage : nco_ctrl_pkg

// File: rtl/nco_step_clamp.sv
// Combinational single step of the sweep: moves current by step toward stop
// and lands exactly on stop instead of passing it. dir=1 means up-sweep.
module nco_step_clamp #(
    parameter int unsigned PHASE_WIDTH = 64
) (
    input  logic signed [PHASE_WIDTH-1:0] current,
    input  logic        [PHASE_WIDTH-1:0] step,
    input  logic signed [PHASE_WIDTH-1:0] stop,
    input  logic                          dir,
    output logic signed [PHASE_WIDTH-1:0] next
);

    localparam int unsigned XW = PHASE_WIDTH + 1;

    logic signed [XW-1:0] cur_x;
    logic signed [XW-1:0] stop_x;
    logic signed [XW-1:0] dist_x;
    logic        [XW-1:0] step_x;
    logic                 reached;

    // Compare step against remaining distance rather than forming current+step
    // first, so no intermediate can exceed PHASE_WIDTH+1 signed bits.
    always_comb begin
        cur_x   = XW'(current);
        stop_x  = XW'(stop);
        step_x  = {1'b0, step};
        dist_x  = dir ? (stop_x - cur_x) : (cur_x - stop_x);
        reached = dist_x[XW-1] || (step_x >= $unsigned(dist_x));
        if (reached) begin
            next = stop;
        end else if (dir) begin
            next = PHASE_WIDTH'(cur_x + $signed(step_x));
        end else begin
            next = PHASE_WIDTH'(cur_x - $signed(step_x));
        end
    end

endmodule : nco_step_clamp

// File: rtl/nco_sweep_controller.sv
// Steps the NCO phase increment through a linear sweep from start to stop,
// holding each value for dwell+1 sample ticks, one-shot or continuous.
module nco_sweep_controller
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int unsigned DWELL_WIDTH = DEF_DWELL_WIDTH
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          sample_clk_ce,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic signed [PHASE_WIDTH-1:0] cfg_start,
    input  logic signed [PHASE_WIDTH-1:0] cfg_stop,
    input  logic        [PHASE_WIDTH-1:0] cfg_step,
    input  logic        [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                          cfg_continuous,
    input  logic                          abort,
    output logic signed [PHASE_WIDTH-1:0] phase_increment,
    output logic                          busy,
    output logic                          done
);

    sweep_state_t state_q;
    sweep_state_t state_d;

    sweep_desc_t  desc_q;
    sweep_desc_t  desc_d;
    logic         dir_q;
    logic         dir_d;

    logic        [DWELL_WIDTH-1:0] dwell_cnt_q;
    logic        [DWELL_WIDTH-1:0] dwell_cnt_d;
    logic signed [PHASE_WIDTH-1:0] phase_d;
    logic                          busy_d;
    logic                          done_d;
    logic                          ready_d;

    logic signed [PHASE_WIDTH-1:0] d_start;
    logic signed [PHASE_WIDTH-1:0] d_stop;
    logic        [PHASE_WIDTH-1:0] d_step;
    logic        [DWELL_WIDTH-1:0] d_dwell;
    logic                          d_cont;
    logic signed [PHASE_WIDTH-1:0] clamp_next;
    logic                          handshake;
    logic                          dwell_zero;
    logic                          expire;
    logic                          at_stop;

    assign d_start    = PHASE_WIDTH'(desc_q.start);
    assign d_stop     = PHASE_WIDTH'(desc_q.stop);
    assign d_step     = PHASE_WIDTH'(desc_q.step);
    assign d_dwell    = DWELL_WIDTH'(desc_q.dwell);
    assign d_cont     = desc_q.continuous;

    assign handshake  = cfg_valid && cfg_ready;
    assign dwell_zero = (dwell_cnt_q == '0);
    assign expire     = sample_clk_ce && dwell_zero;
    assign at_stop    = (phase_increment == d_stop);

    nco_step_clamp #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_step_clamp (
        .current (phase_increment),
        .step    (d_step),
        .stop    (d_stop),
        .dir     (dir_q),
        .next    (clamp_next)
    );

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a coincident dwell expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (expire && at_stop && !d_cont) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the descriptor, dwell counter and registered outputs.
    always_comb begin
        desc_d      = desc_q;
        dir_d       = dir_q;
        phase_d     = phase_increment;
        dwell_cnt_d = dwell_cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    desc_d.start      = DEF_PHASE_WIDTH'(cfg_start);
                    desc_d.stop       = DEF_PHASE_WIDTH'(cfg_stop);
                    desc_d.step       = DEF_PHASE_WIDTH'(cfg_step);
                    desc_d.dwell      = DEF_DWELL_WIDTH'(cfg_dwell);
                    desc_d.continuous = cfg_continuous;
                    dir_d             = (cfg_stop > cfg_start);
                    phase_d           = cfg_start;
                    dwell_cnt_d       = cfg_dwell;
                end
            end
            SWEEP: begin
                if (!abort && sample_clk_ce) begin
                    if (!dwell_zero) begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
                    end else begin
                        dwell_cnt_d = d_dwell;
                        if (!at_stop) begin
                            phase_d = clamp_next;
                        end else if (d_cont) begin
                            phase_d = d_start;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
        ready_d = (state_d == IDLE);
    end

    // Datapath and output registers; reset discards the latched descriptor.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            desc_q          <= '0;
            dir_q           <= 1'b0;
            dwell_cnt_q     <= '0;
            phase_increment <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_ready       <= 1'b1;
        end else begin
            desc_q          <= desc_d;
            dir_q           <= dir_d;
            dwell_cnt_q     <= dwell_cnt_d;
            phase_increment <= phase_d;
            busy            <= busy_d;
            done            <= done_d;
            cfg_ready       <= ready_d;
        end
    end

endmodule : nco_sweep_controller

// File: doc/nco_sweep_controller.md
# nco_sweep_controller

Sequences the `phase_increment` input of the quadrature sinewave generator (NCO) so the SDR front end can run linear frequency sweeps and hops without CPU involvement. It accepts one sweep descriptor per handshake (start, stop, step, dwell, mode) and steps the increment on `sample_clk_ce` ticks. It holds each value for a programmable dwell and clamps exactly at the stop value. It sits between the control/register interface and the NCO, in the `clk` domain, and shares the NCO's `sample_clk_ce`.

## Interface
- PHASE_WIDTH, 64, width of phase increment (matches NCO)
- DWELL_WIDTH, 16, width of dwell counter
- clk  in  1  system clock
- arst  in  1  reset, asynchronous, active-high
- sample_clk_ce  in  1  sample-rate clock enable (same strobe driving the NCO)
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready
- cfg_start  in  PHASE_WIDTH signed  first increment
- cfg_stop  in  PHASE_WIDTH signed  final increment
- cfg_step  in  PHASE_WIDTH unsigned  step magnitude; direction from sign(stop−start)
- cfg_dwell  in  DWELL_WIDTH  extra ce ticks each value is held (hold = dwell+1 ticks)
- cfg_continuous  in  1  1: restart at start after stop; 0: one-shot
- abort  in  1  terminate the sweep
- phase_increment  out  PHASE_WIDTH signed  to NCO
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at one-shot completion

## Operation
- FSM states: IDLE, SWEEP, FINISH.
- IDLE:
  - cfg_ready=1.
  - On handshake, latch the descriptor; next cycle phase_increment=cfg_start, dwell_cnt=cfg_dwell, go to SWEEP.
- SWEEP:
  - cfg_ready=0; cfg_valid is ignored.
  - Each sample_clk_ce with dwell_cnt≠0 decrements dwell_cnt.
  - Each sample_clk_ce with dwell_cnt=0 reloads dwell_cnt=dwell, then:
    - phase_increment≠stop: phase_increment ← clamp(phase_increment ± step) toward stop.
    - phase_increment=stop and continuous: phase_increment ← start.
    - phase_increment=stop and one-shot: go to FINISH; phase_increment holds stop.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Clamp arithmetic:
  - Compute next in PHASE_WIDTH+1 bits signed.
  - Up-sweep: if next ≥ stop, then stop. Down-sweep: if next ≤ stop, then stop.
  - No wrap-around under any start, stop or step combination.
- step=0 with start≠stop: the sweep never reaches stop; continuous holds start indefinitely. One-shot is terminated only by abort.
- start=stop: the stop condition is true at the first dwell expiry.
- abort (any state except IDLE): next cycle IDLE; phase_increment holds its current value; done is not asserted. abort has priority over a simultaneous ce step.
- In IDLE, phase_increment holds its last value (the NCO keeps running).

## Timing
- Reset values: phase_increment=0, busy=0, done=0, cfg_ready=1, state=IDLE, dwell_cnt=0.
- arst mid-sweep returns all outputs to reset values immediately. The latched descriptor is discarded.
- Latency: handshake at edge N puts start on phase_increment after edge N+1. The first ce counted is at or after edge N+1.
- Each value is presented for exactly dwell+1 ce ticks. A one-shot sweep of K distinct values asserts done one cycle after the K·(dwell+1)-th ce.
- busy=1 in SWEEP and FINISH; busy falls in the same cycle the state returns to IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- A new descriptor is accepted in the same cycle busy reads 0 (back-to-back sweeps need one idle cycle).

## Structure
- Package nco_ctrl_pkg holds:
  - the state enum (IDLE, SWEEP, FINISH);
  - default PHASE_WIDTH and DWELL_WIDTH localparams;
  - the descriptor struct {start, stop, step, dwell, continuous}.
- Sub-module nco_step_clamp: purely combinational. Inputs: current, step, stop, dir. Output: next clamped increment. Unit-tested separately.
- The top level holds the FSM, the descriptor register and the dwell counter.

## Test plan
- One-shot up sweep: start=100, stop=130, step=10, dwell=2, ce every cycle. Required: 100,110,120,130 each held 3 ticks; done pulse after the 12th ce; busy falls with it.
- Overshoot clamp, down sweep: start=50, stop=−7, step=20, dwell=0. Required: 50,30,10,−7 then done; no value beyond −7.
- Continuous mode: start=0, stop=4, step=2, dwell=0, ce every 3rd cycle. Required: 0,2,4,0,2,4… with no done pulse; abort then returns busy=0 and holds the current value.
- Handshake: a second cfg_valid during SWEEP is not accepted (cfg_ready=0); it is accepted the first cycle after done, and start appears on the following cycle.
- Simultaneous abort and ce at dwell expiry: the increment does not step; IDLE on the next cycle; done stays 0.
- arst asserted mid-sweep at value 120: phase_increment=0, busy=0, cfg_ready=1 immediately; a new sweep after reset release behaves normally.
